toggle_handshake_rx: RTL and testbench
======================================

// Module: toggle_handshake_rx
// PURPOSE
//  Receiving end of the toggle (two-phase) handshake driven by a T flip-flop style transmitter.
//  Each level change on req_tgl means one new word is on req_data.
//  The block captures the word into a FIFO, answers by toggling ack_tgl, and presents the
//  buffered words on a valid/ready stream.
//  Transmitter and receiver share one clock domain.
// PARAMETERS
//  WIDTH   8   bits per data word
//  DEPTH   4   FIFO entries (power of 2, >=2)
//  CNT_W   16  width of the event and stall statistic counters
// PORTS
//  clk         in   1            rising-edge clock
//  reset       in   1            synchronous, active-high reset
//  req_tgl     in   1            request toggle from the transmitter
//  req_data    in   WIDTH        data word; stable while a request is pending
//  ack_tgl     out  1            acknowledge toggle back to the transmitter
//  out_valid   out  1            FIFO head word valid
//  out_data    out  WIDTH        FIFO head word
//  out_ready   in   1            consumer accepts the head word when out_valid=1
//  fifo_count  out  $clog2(DEPTH)+1  number of words currently stored
//  event_cnt   out  CNT_W        number of words accepted; wraps modulo 2^CNT_W
//  stall_cnt   out  CNT_W        cycles spent in STALL; saturates at all-ones
// BEHAVIOUR
//  - Reset, applied at the clk edge while reset=1:
//      ack_tgl=0, out_valid=0, out_data=0, fifo_count=0, event_cnt=0, stall_cnt=0.
//      FIFO pointers are cleared, FSM goes to IDLE.
//      A reset in the middle of an operation discards the stored words and any pending request.
//      The transmitter is reset by the same reset, so req_tgl=0 is expected after reset.
//  - pending = req_tgl ^ ack_tgl. This is a level comparison, with no separate edge detector.
//  - pop = out_valid & out_ready.
//  - space = (fifo_count < DEPTH) | pop. A pop in the same cycle frees a slot.
//  - push = pending & space & ~reset.
//      On a push, req_data is written at the tail, ack_tgl inverts, and event_cnt increments.
//      ack_tgl changes one cycle after req_tgl at the earliest.
//      With ack_tgl inverted, pending clears, so there is exactly one push per toggle.
//  - FSM:
//      IDLE : pending=0. Goes to STALL if pending & ~space; otherwise stays
//             (a push happens in the same cycle).
//      STALL: pending=1 and FIFO full with no pop. stall_cnt +1 per cycle, saturating.
//             Goes to IDLE on the cycle a push happens.
//  - Latency: a word pushed at edge N drives out_valid=1 and out_data after edge N.
//      There is no bypass, even when the FIFO is empty.
//  - Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
//      When full, the pop slot is reused in the same cycle.
//  - Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
//  - out_data holds the head word while out_valid=1 and out_ready=0. It holds its last value
//    when the FIFO is empty.
//  - A second toggle on req_tgl before ack_tgl answers is a protocol violation. Behaviour is
//    then undefined; no detection is required.
// TESTING
//  1. Reset with req_tgl=0.
//     -> All outputs 0; out_valid stays 0 for 5 idle cycles.
//  2. req_data=8'hA5 then toggle req_tgl 0->1, with out_ready=1.
//     -> ack_tgl=1 one cycle later.
//     -> out_valid=1 with out_data=8'hA5 for one cycle.
//     -> event_cnt=1.
//  3. out_ready=0; send 4 toggles with data 11,22,33,44, each after its ack.
//     -> fifo_count=4.
//     -> A 5th toggle with data 55 leaves ack_tgl unchanged; FSM in STALL; stall_cnt counts.
//     -> Raise out_ready: 11 pops, 55 is pushed in that same cycle, ack toggles.
//     -> Words come out in order 11,22,33,44,55.
//  4. FIFO full with a pending request and out_ready=1 held.
//     -> fifo_count stays 4 on the push+pop cycle.
//     -> No word is lost or duplicated.
//  5. Assert reset with fifo_count=3 and a request pending.
//     -> Next cycle: fifo_count=0, out_valid=0, ack_tgl=0, event_cnt=0.
//  6. CNT_W=4, 17 transfers.
//     -> event_cnt wraps to 1.
//     -> A stall of 20 cycles leaves stall_cnt=15, saturated.

Source files
------------

// File: rtl/toggle_handshake_rx_if.sv
// Bus bundle between the toggle-handshake transmitter/consumer and the receiver.
// The receiver attaches through the slave modport; the driving side uses master.
interface toggle_handshake_rx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                     req_tgl;
    logic [WIDTH-1:0]         req_data;
    logic                     ack_tgl;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [CNT_W-1:0]         event_cnt;
    logic [CNT_W-1:0]         stall_cnt;

    modport slave (
        input  req_tgl, req_data, out_ready,
        output ack_tgl, out_valid, out_data, fifo_count, event_cnt, stall_cnt
    );

    modport master (
        output req_tgl, req_data, out_ready,
        input  ack_tgl, out_valid, out_data, fifo_count, event_cnt, stall_cnt
    );
endinterface

// File: rtl/toggle_handshake_rx.sv
// Two-phase (toggle) handshake receiver: each req_tgl level change pushes one word into a
// small FIFO, ack_tgl answers the push, and the FIFO drains on a valid/ready stream.
module toggle_handshake_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    toggle_handshake_rx_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, STALL} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ack_q, ack_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   event_q, event_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               pending, pop, space, push;
    logic [CW-1:0]      remain;

    always_comb begin
        pending = bus.req_tgl ^ ack_q;
        pop     = (count_q != '0) & bus.out_ready;
        space   = (count_q < FULL) | pop;
        push    = pending & space & ~reset;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        ack_d    = ack_q ^ push;
        event_d  = event_q + CNT_W'(push);
        stall_d  = stall_q;
        data_d   = data_q;
        state_d  = state_q;
        remain   = count_q - CW'(pop);

        if (state_q == STALL && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end

        // Registered head word; when the FIFO drains to the incoming word, take it straight
        // from req_data because the memory write lands on the same edge.
        if (count_d != '0) begin
            data_d = (remain == '0) ? bus.req_data : mem_q[rd_ptr_d];
        end

        case (state_q)
            IDLE:    if (pending & ~space) state_d = STALL;
            STALL:   if (push)             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            data_q   <= '0;
            event_q  <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            event_q  <= event_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.req_data;
        end
    end

    assign bus.ack_tgl    = ack_q;
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_data   = data_q;
    assign bus.fifo_count = count_q;
    assign bus.event_cnt  = event_q;
    assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Bench for toggle_handshake_rx: directed scenarios then random traffic, against a queue-based
// reference. A second instance with 4-bit counters shares the stimulus to cover wrap/saturation.
module tb_toggle_handshake_rx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int SCW   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    toggle_handshake_rx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    toggle_handshake_rx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(SCW))   sbus ();

    assign sbus.req_tgl   = bus.req_tgl;
    assign sbus.req_data  = bus.req_data;
    assign sbus.out_ready = bus.out_ready;

    toggle_handshake_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    toggle_handshake_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(SCW)) dut_s (
        .clk(clk), .reset(reset), .bus(sbus)
    );

    int total = 0;
    int bad   = 0;

    // reference state: stored words, ack level, last head word, counters
    logic [WIDTH-1:0] m_q[$];
    bit               m_ack;
    logic [WIDTH-1:0] m_data;
    int unsigned      m_ev;
    int unsigned      m_st;
    bit               m_blocked;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        bit pending, pop, space, push;
        if (reset) begin
            m_q.delete();
            m_ack = 1'b0; m_data = '0; m_ev = 0; m_st = 0; m_blocked = 1'b0;
            return;
        end
        pending = bus.req_tgl ^ m_ack;
        pop     = (m_q.size() > 0) && bus.out_ready;
        space   = (m_q.size() < DEPTH) || pop;
        push    = pending && space;
        if (m_blocked) m_st++;
        m_blocked = pending && !space;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(bus.req_data);
            m_ack = ~m_ack;
            m_ev++;
        end
        if (m_q.size() > 0) m_data = m_q[0];
    endtask

    task automatic check_all();
        check_val("ack",      bus.ack_tgl,     m_ack);
        check_val("valid",    bus.out_valid,   m_q.size() > 0);
        check_val("data",     bus.out_data,    m_data);
        check_val("count",    bus.fifo_count,  m_q.size());
        check_val("event",    bus.event_cnt,   m_ev % 65536);
        check_val("stall",    bus.stall_cnt,   sat(m_st, 65535));
        check_val("s_ack",    sbus.ack_tgl,    m_ack);
        check_val("s_valid",  sbus.out_valid,  m_q.size() > 0);
        check_val("s_data",   sbus.out_data,   m_data);
        check_val("s_count",  sbus.fifo_count, m_q.size());
        check_val("s_event",  sbus.event_cnt,  m_ev % 16);
        check_val("s_stall",  sbus.stall_cnt,  sat(m_st, 15));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        bus.req_data = d;
        bus.req_tgl  = ~bus.req_tgl;
        step();
    endtask

    initial begin
        logic [WIDTH-1:0] tail [4];
        tail = '{8'h22, 8'h33, 8'h44, 8'h55};

        reset = 1'b1;
        bus.req_tgl = 1'b0; bus.req_data = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        step(); step();
        check_val("rst_valid", bus.out_valid, 0);
        check_val("rst_count", bus.fifo_count, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("idle_valid", bus.out_valid, 0);
        end

        // single word with consumer ready
        bus.out_ready = 1'b1;
        send(8'hA5);
        check_val("t2_ack", bus.ack_tgl, 1);
        check_val("t2_data", bus.out_data, 8'hA5);
        check_val("t2_event", bus.event_cnt, 1);
        step();
        check_val("t2_drain", bus.out_valid, 0);

        // fill, stall, then release
        bus.out_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check_val("t3_full", bus.fifo_count, 4);
        send(8'h55);
        check_val("t3_noack", bus.ack_tgl, 1);
        step(); step(); step();
        check_val("t3_stall", bus.stall_cnt, 3);
        check_val("t3_head", bus.out_data, 8'h11);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t3_order", bus.out_data, tail[i]);
            if (i == 0) begin
                check_val("t3_swap_cnt", bus.fifo_count, 4);
                check_val("t3_swap_ack", bus.ack_tgl, 0);
            end
        end
        step();
        check_val("t3_empty", bus.out_valid, 0);

        // full with ready held: push and pop share a cycle
        bus.out_ready = 1'b0;
        send(8'h66); send(8'h77); send(8'h88); send(8'h99);
        bus.out_ready = 1'b1;
        send(8'hAA);
        check_val("t4_count", bus.fifo_count, 4);
        send(8'hBB); send(8'hCC);
        repeat (6) step();

        // reset with words stored and a request pending
        bus.out_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03);
        check_val("t5_pre", bus.fifo_count, 3);
        bus.req_data = 8'h04;
        bus.req_tgl  = ~bus.req_tgl;
        reset = 1'b1;
        step();
        check_val("t5_count", bus.fifo_count, 0);
        check_val("t5_valid", bus.out_valid, 0);
        check_val("t5_ack", bus.ack_tgl, 0);
        check_val("t5_event", bus.event_cnt, 0);
        reset = 1'b0;
        bus.req_tgl = 1'b0;
        step();

        // narrow counters: event wrap and stall saturation
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(WIDTH'(i + 8'h30));
        check_val("t6_wrap", sbus.event_cnt, 1);
        bus.out_ready = 1'b0;
        while (m_q.size() < DEPTH) send(WIDTH'($urandom));
        send(8'hEE);
        repeat (20) step();
        check_val("t6_sat", sbus.stall_cnt, 15);
        check_val("t6_wide", bus.stall_cnt, 20);
        bus.out_ready = 1'b1;
        repeat (6) step();

        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                bus.req_tgl = 1'b0;
            end else begin
                reset = 1'b0;
                if (bus.req_tgl == bus.ack_tgl && $urandom_range(0, 2) != 0) begin
                    bus.req_data = WIDTH'($urandom);
                    bus.req_tgl  = ~bus.req_tgl;
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
